stream_mux_rr: RTL and testbench



---
 rtl/stream_mux_rr.sv | 145 ++++++++++++++
 tb/tb_stream_mux_rr.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/stream_mux_rr.sv
`default_nettype none
// ============================================================================
//  Module   : stream_mux_rr
//  Purpose  : N:1 valid/ready stream mux with a one-beat registered output.
//             Selection is round-robin or a fixed selector, chosen at run time.
//             Optional packet lock: define STREAM_MUX_PKT_LOCK_EN.
//  Revision : 1.0  initial release
// ============================================================================
module stream_mux_rr #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4,
   parameter int SEL_W    = $clog2(CHANNELS)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      mode,
   input  logic [SEL_W-1:0]          selector,
   input  logic [CHANNELS*WIDTH-1:0] in_data,
   input  logic [CHANNELS-1:0]       in_valid,
`ifdef STREAM_MUX_PKT_LOCK_EN
   input  logic [CHANNELS-1:0]       in_last,
   output logic                      out_last,
`endif
   output logic [CHANNELS-1:0]       in_ready,
   output logic [WIDTH-1:0]          out_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [SEL_W-1:0]          out_sel
);

   localparam logic [SEL_W:0]   c_CHANNELS = (SEL_W+1)'(CHANNELS);
   localparam logic [SEL_W-1:0] c_LAST_CH  = SEL_W'(CHANNELS - 1);

   logic [WIDTH-1:0]    r_out_data;
   logic                r_out_valid;
   logic [SEL_W-1:0]    r_out_sel;
   logic [SEL_W-1:0]    r_ptr;

   logic                w_load_en;
   logic                w_rr_found;
   logic [SEL_W-1:0]    w_rr_idx;
   logic [SEL_W-1:0]    w_cand;
   logic                w_sel_ok;
   logic                w_found;
   logic [SEL_W-1:0]    w_idx;
   logic [CHANNELS-1:0] w_grant;
   logic [WIDTH-1:0]    w_beat;
   logic [SEL_W-1:0]    w_ptr_next;

`ifdef STREAM_MUX_PKT_LOCK_EN
   logic                r_locked;
   logic [SEL_W-1:0]    r_lock_ch;
   logic                r_out_last;
`endif

   assign w_load_en = !r_out_valid || out_ready;
   assign w_sel_ok  = ({1'b0, selector} < c_CHANNELS);

   // Round-robin scan: first valid channel at or above the pointer, wrapping.
   always_comb begin
      w_rr_found = 1'b0;
      w_rr_idx   = '0;
      w_cand     = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         w_cand = SEL_W'((int'(r_ptr) + k) % CHANNELS);
         if (!w_rr_found && in_valid[w_cand]) begin
            w_rr_found = 1'b1;
            w_rr_idx   = w_cand;
         end
      end
   end

   always_comb begin
      w_found = 1'b0;
      w_idx   = '0;
      if (mode) begin
         w_idx   = selector;
         w_found = w_sel_ok && in_valid[selector];
      end else begin
         w_idx   = w_rr_idx;
         w_found = w_rr_found;
      end
`ifdef STREAM_MUX_PKT_LOCK_EN
      // An open packet owns the output even while its channel is idle.
      if (r_locked) begin
         w_idx   = r_lock_ch;
         w_found = in_valid[r_lock_ch];
      end
`endif
   end

   always_comb begin
      w_grant = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         w_grant[i] = w_found && (w_idx == SEL_W'(i));
      end
   end

   assign w_beat     = in_data[int'(w_idx)*WIDTH +: WIDTH];
   assign w_ptr_next = (w_idx == c_LAST_CH) ? '0 : w_idx + 1'b1;
   assign in_ready   = (rst_n && w_load_en) ? w_grant : '0;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
         r_out_sel   <= '0;
         r_ptr       <= '0;
`ifdef STREAM_MUX_PKT_LOCK_EN
         r_locked    <= 1'b0;
         r_lock_ch   <= '0;
         r_out_last  <= 1'b0;
`endif
      end else if (w_load_en) begin
         if (w_found) begin
            r_out_data  <= w_beat;
            r_out_sel   <= w_idx;
            r_out_valid <= 1'b1;
`ifdef STREAM_MUX_PKT_LOCK_EN
            r_out_last  <= in_last[w_idx];
            if (in_last[w_idx]) begin
               r_locked <= 1'b0;
               if (!mode) r_ptr <= w_ptr_next;
            end else begin
               r_locked  <= 1'b1;
               r_lock_ch <= w_idx;
            end
`else
            if (!mode) r_ptr <= w_ptr_next;
`endif
         end else begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign out_data  = r_out_data;
   assign out_valid = r_out_valid;
   assign out_sel   = r_out_sel;
`ifdef STREAM_MUX_PKT_LOCK_EN
   assign out_last  = r_out_last;
`endif

endmodule
`default_nettype wire

// File: tb/tb_stream_mux_rr.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stream_mux_rr
//  Purpose  : Directed scoreboard bench for stream_mux_rr (4- and 3-channel).
//  Revision : 1.0  initial release
// ============================================================================
module tb_stream_mux_rr;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mode;
   logic [1:0]  selector;
   logic [31:0] in_data;
   logic [3:0]  in_valid;
   logic [3:0]  in_ready;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready;
   logic [1:0]  out_sel;

   logic        mode3;
   logic [1:0]  selector3;
   logic [23:0] in_data3;
   logic [2:0]  in_valid3;
   logic [2:0]  in_ready3;
   logic [7:0]  out_data3;
   logic        out_valid3;
   logic        out_ready3;
   logic [1:0]  out_sel3;

`ifdef STREAM_MUX_PKT_LOCK_EN
   logic [3:0]  in_last;
   logic        out_last;
   logic [2:0]  in_last3;
   logic        out_last3;
`endif

   int checks   = 0;
   int failures = 0;
   logic [10:0] sb[$];

   always #5 clk = ~clk;

   stream_mux_rr #(.WIDTH(8), .CHANNELS(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .mode(mode), .selector(selector),
      .in_data(in_data), .in_valid(in_valid),
`ifdef STREAM_MUX_PKT_LOCK_EN
      .in_last(in_last), .out_last(out_last),
`endif
      .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .out_sel(out_sel)
   );

   stream_mux_rr #(.WIDTH(8), .CHANNELS(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .mode(mode3), .selector(selector3),
      .in_data(in_data3), .in_valid(in_valid3),
`ifdef STREAM_MUX_PKT_LOCK_EN
      .in_last(in_last3), .out_last(out_last3),
`endif
      .in_ready(in_ready3), .out_data(out_data3), .out_valid(out_valid3),
      .out_ready(out_ready3), .out_sel(out_sel3)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic last, input logic [1:0] sel, input logic [7:0] data);
      sb.push_back({last, sel, data});
   endtask

   // Called just after inputs change; checks in_ready, retires a consumed beat, advances one clock.
   task automatic cyc(input string tag, input logic [3:0] exp_rdy);
      logic [10:0] e;
      #2;
      chk({tag, ".in_ready"}, 32'(in_ready), 32'(exp_rdy));
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
         if (sb.size() == 0) begin
            chk({tag, ".extra_beat"}, 32'(out_valid), 32'd0);
         end else begin
            e = sb.pop_front();
            chk({tag, ".out_data"}, 32'(out_data), 32'(e[7:0]));
            chk({tag, ".out_sel"},  32'(out_sel),  32'(e[9:8]));
`ifdef STREAM_MUX_PKT_LOCK_EN
            chk({tag, ".out_last"}, 32'(out_last), 32'(e[10]));
`endif
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n     = 1'b0;
      mode      = 1'b0;
      selector  = 2'd0;
      in_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
      in_valid  = 4'b1111;
      out_ready = 1'b1;
      mode3 = 1'b0; selector3 = 2'd0; in_data3 = {8'hC2, 8'hC1, 8'hC0};
      in_valid3 = 3'b000; out_ready3 = 1'b1;
`ifdef STREAM_MUX_PKT_LOCK_EN
      in_last  = 4'b1111;
      in_last3 = 3'b111;
`endif
      @(posedge clk); #1;

      // Reset with every channel requesting
      cyc("rst", 4'b0000);
      chk("rst.out_valid", 32'(out_valid), 32'd0);
      chk("rst.out_data",  32'(out_data),  32'd0);
      chk("rst.out_sel",   32'(out_sel),   32'd0);

      // Round-robin fairness
      rst_n = 1'b1;
      push(1'b1, 2'd0, 8'hA0); cyc("rr0", 4'b0001);
      push(1'b1, 2'd1, 8'hA1); cyc("rr1", 4'b0010);
      push(1'b1, 2'd2, 8'hA2); cyc("rr2", 4'b0100);
      push(1'b1, 2'd3, 8'hA3); cyc("rr3", 4'b1000);
      push(1'b1, 2'd0, 8'hA0); cyc("rr4", 4'b0001);

      // Sparse requests, then pointer-wrap to the only valid channel
      in_valid = 4'b1010;
      push(1'b1, 2'd1, 8'hA1); cyc("sp0", 4'b0010);
      push(1'b1, 2'd3, 8'hA3); cyc("sp1", 4'b1000);
      push(1'b1, 2'd1, 8'hA1); cyc("sp2", 4'b0010);
      push(1'b1, 2'd3, 8'hA3); cyc("sp3", 4'b1000);
      in_valid = 4'b1000;
      push(1'b1, 2'd3, 8'hA3); cyc("wrap", 4'b1000);

      // Fixed selector, fresh ch2 data each beat
      mode = 1'b1; selector = 2'd2; in_valid = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         in_data[23:16] = 8'(8'h20 + k);
         push(1'b1, 2'd2, 8'(8'h20 + k));
         cyc("fix", 4'b0100);
      end
      in_valid = 4'b0000;
      cyc("fix_drain", 4'b0000);
      chk("idle.out_valid", 32'(out_valid), 32'd0);
      chk("idle.out_data",  32'(out_data),  32'h24);
      chk("idle.out_sel",   32'(out_sel),   32'd2);

      // Back-pressure holds the beat and blocks every input
      mode = 1'b0; in_data = {8'hA3, 8'hA2, 8'hA1, 8'h55}; in_valid = 4'b0001;
      push(1'b1, 2'd0, 8'h55); cyc("bp_load", 4'b0001);
      out_ready = 1'b0; in_valid = 4'b1111;
      for (int k = 0; k < 3; k++) begin
         cyc("bp", 4'b0000);
         chk("bp.out_valid", 32'(out_valid), 32'd1);
         chk("bp.out_data",  32'(out_data),  32'h55);
         chk("bp.out_sel",   32'(out_sel),   32'd0);
      end
      out_ready = 1'b1;
      push(1'b1, 2'd1, 8'hA1); cyc("bp_rel", 4'b0010);
      in_valid = 4'b0000;
      cyc("bp_drain", 4'b0000);

      // Reset while a beat is held: beat discarded, pointer cleared
      in_valid = 4'b0001;
      cyc("mr_load", 4'b0001);
      out_ready = 1'b0; rst_n = 1'b0;
      cyc("mr_rst", 4'b0000);
      chk("mr.out_valid", 32'(out_valid), 32'd0);
      chk("mr.out_data",  32'(out_data),  32'd0);
      rst_n = 1'b1; out_ready = 1'b1; in_valid = 4'b1111;
      in_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
      push(1'b1, 2'd0, 8'hA0); cyc("mr_post", 4'b0001);
      in_valid = 4'b0000;
      cyc("mr_drain", 4'b0000);

      // Three-channel instance: selector beyond the last channel grants nothing
      mode3 = 1'b1; selector3 = 2'd2; in_valid3 = 3'b111;
      #1; chk("d3.in_ready_sel2", 32'(in_ready3), 32'b100);
      cyc("d3a", 4'b0000);
      chk("d3.out_valid_sel2", 32'(out_valid3), 32'd1);
      chk("d3.out_sel_sel2",   32'(out_sel3),   32'd2);
      selector3 = 2'd3;
      #1; chk("d3.in_ready_sel3", 32'(in_ready3), 32'b000);
      cyc("d3b", 4'b0000);
      chk("d3.out_valid_sel3", 32'(out_valid3), 32'd0);
      chk("d3.out_data_hold",  32'(out_data3),  32'hC2);

`ifdef STREAM_MUX_PKT_LOCK_EN
      // Packet lock: ch0 3-beat packet with ch1 waiting
      rst_n = 1'b0;
      cyc("pk_rst", 4'b0000);
      rst_n = 1'b1;
      in_valid = 4'b0011; in_last = 4'b1110; in_data[7:0] = 8'h10;
      push(1'b0, 2'd0, 8'h10); cyc("pk0", 4'b0001);
      in_valid = 4'b0010;
      cyc("pk_idle", 4'b0000);
      in_valid = 4'b0011; in_data[7:0] = 8'h11;
      push(1'b0, 2'd0, 8'h11); cyc("pk1", 4'b0001);
      in_last = 4'b1111; in_data[7:0] = 8'h12;
      push(1'b1, 2'd0, 8'h12); cyc("pk2", 4'b0001);
      in_data[7:0] = 8'h13;
      push(1'b1, 2'd1, 8'hA1); cyc("pk_next", 4'b0010);
      in_valid = 4'b0000;
      cyc("pk_drain", 4'b0000);
`endif

      chk("sb.empty", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
